// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the boot-loader byte stream and its instruction-memory write port.
//   byte_in    : stream data byte (source -> loader)
//   byte_valid : byte_in is valid this cycle (source -> loader)
//   byte_ready : loader can accept a byte this cycle (loader -> source)
//   imem_we    : instruction-memory write strobe (loader -> memory)
//   imem_addr  : instruction-memory word address (loader -> memory)
//   imem_wdata : assembled 32-bit instruction word (loader -> memory)
// master = stream source / memory side, slave = the loader itself.
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Boot-time loader in front of the CPU instruction memory. Receives an image
// (16-bit big-endian word count, then count x 4 bytes) over a valid/ready
// byte stream, packs big-endian 32-bit words and writes them to consecutive
// word addresses starting at 0. The CPU is held in reset until the whole
// image has been written.
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : one-cycle pulse, starts a load from IDLE/DONE/ERROR
//   bus          : byte stream + instruction-memory write port (slave view)
//   cpu_hold     : 1 = keep the CPU in reset
//   busy         : load in progress (LEN_HI, LEN_LO, DATA, WRITE)
//   done         : level, image loaded successfully
//   error        : level, length field was 0 or larger than memory
//   words_loaded : words written during the current load
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  imem_boot_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CAPACITY = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       length_q, length_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   wl_inc;
  logic              len_bad;
  logic              last_word;

  // A byte moves only when the registered ready meets valid on the same edge.
  assign xfer      = bus.byte_valid & byte_ready_q;
  assign len_full  = {len_hi_q, bus.byte_in};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > CAPACITY);
  assign wl_inc    = words_loaded_q + (ADDR_W+1)'(1);
  assign last_word = (32'(wl_inc) == 32'(length_q));

  always_comb begin
    state_d        = state_q;
    len_hi_d       = len_hi_q;
    length_d       = length_q;
    idx_d          = idx_q;
    word_d         = word_q;
    words_loaded_d = words_loaded_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = done_q;
    error_d        = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d        = S_LEN_HI;
          cpu_hold_d     = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = bus.byte_in;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          length_d = len_full;
          if (len_bad) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
            idx_d   = 2'd0;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          case (idx_q)
            2'd0:    word_d[31:24] = bus.byte_in;
            2'd1:    word_d[23:16] = bus.byte_in;
            2'd2:    word_d[15:8]  = bus.byte_in;
            default: word_d[7:0]   = bus.byte_in;
          endcase
          idx_d = idx_q + 2'd1;
          // Fourth byte: the write strobe is registered so it appears
          // exactly in the WRITE cycle with the completed word.
          if (idx_q == 2'd3) begin
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = words_loaded_q[ADDR_W-1:0];
            imem_wdata_d = word_d;
          end
        end
      end

      S_WRITE: begin
        words_loaded_d = wl_inc;
        if (last_word) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d = S_DATA;
          idx_d   = 2'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Ready and busy are registered from the next state so they line up
    // with the state they describe and have no path from byte_valid.
    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA);
    busy_d       = byte_ready_d || (state_d == S_WRITE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_hi_q       <= '0;
      length_q       <= '0;
      idx_q          <= '0;
      word_q         <= '0;
      words_loaded_q <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      byte_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_hi_q       <= len_hi_d;
      length_q       <= length_d;
      idx_q          <= idx_d;
      word_q         <= word_d;
      words_loaded_q <= words_loaded_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      byte_ready_q   <= byte_ready_d;
      busy_q         <= busy_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the CPU in reset until the programme image is completely loaded.
- Image format: 16-bit big-endian word count, followed by count×4 data bytes.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity = 2^ADDR_W words.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  instruction-memory word address.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  1 = CPU held in reset; drive into the CPU reset.
- busy  output  1  high in LEN_HI, LEN_LO, DATA and WRITE.
- done  output  1  level; load completed successfully.
- error  output  1  level; bad length field.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, words_loaded=0, length and byte counters cleared.
- Transfer occurs only on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is a registered function of state: 1 in LEN_HI, LEN_LO, DATA; 0 elsewhere. byte_in is ignored without a transfer. Gaps in byte_valid stall the machine indefinitely (no timeout).
- IDLE: wait for start. On start, go to LEN_HI, set cpu_hold=1, clear done, error and words_loaded.
- LEN_HI: on transfer, length[15:8]=byte_in, then go to LEN_LO.
- LEN_LO: on transfer, length[7:0]=byte_in.
  - If the new length is 0 or greater than 2^ADDR_W, go to ERROR.
  - Otherwise go to DATA with byte index 0.
- DATA: on each transfer, place the byte big-endian. Byte index 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]. On the transfer of index 3, go to WRITE.
- WRITE, exactly one cycle:
  - imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=the assembled word.
  - Next edge: words_loaded+1.
  - If words_loaded+1 == length, go to DONE; else go to DATA with byte index 0.
  - Write latency is 1 cycle after the 4th byte's transfer edge; the next byte is accepted no earlier than 1 cycle after WRITE.
- DONE: cpu_hold=0, done=1, busy=0. imem_we=0. imem_addr and words_loaded hold their values.
- ERROR: error=1, cpu_hold=1, busy=0. No memory writes occur.
- start from DONE or ERROR begins a new load (to LEN_HI) with cpu_hold=1 in the same cycle. start during LEN_HI, LEN_LO, DATA or WRITE is ignored.
- Maximum image (length=2^ADDR_W): the last write goes to address 2^ADDR_W−1 and words_loaded reaches 2^ADDR_W, hence its width ADDR_W+1. The address never wraps.
- Reset asserted mid-load aborts immediately to the reset values. Words already written remain in memory; the loader does not clear it.
- All outputs are registered; no combinational path from byte_valid to byte_ready.

Test Plan:
- Reset: hold reset=0 for 3 cycles → cpu_hold=1, byte_ready=0, imem_we=0, done=0, error=0, words_loaded=0. Then start pulse → byte_ready=1 the next cycle, busy=1.
- Two-word load, bytes sent back-to-back: 00 02 | 20 08 00 05 | AC 08 00 04.
  - Exactly two imem_we pulses: addr 0 data 0x20080005, then addr 1 data 0xAC080004.
  - Then done=1, cpu_hold=0, words_loaded=2.
- Same image with byte_valid toggling 1/0 every cycle and random 0–5 cycle gaps → identical writes and final state. No byte is lost or duplicated; byte_ready=0 throughout WRITE.
- Length fields with ADDR_W=8:
  - 00 00 → error=1, cpu_hold=1, no imem_we.
  - 01 01 (257) → error=1.
  - 01 00 (256) → 256 writes, last at addr 0xFF, done=1, words_loaded=256.
- Reset mid-load: assert reset=0 after 6 data bytes of a 3-word load → all outputs return to reset values asynchronously. A fresh start and a full load afterwards complete normally.
- start pulses issued during DATA are ignored (no restart, writes unchanged). start in DONE relaunches the load: cpu_hold=1 and done=0 on the next cycle.
